// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small byte FIFO feeding an LSB-first
// serialiser whose bit period comes from a runtime clock divisor.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic [DIV_W-1:0]              clk_div,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx_o,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [7:0]       shift_q;
  logic [2:0]       bit_cnt;
  logic [DIV_W-1:0] baud_cnt;
  logic [DIV_W-1:0] period_q;
  logic [DIV_W-1:0] period_new;
  logic             push, pop, fifo_empty, bit_done;

  // Ready depends only on registered occupancy, never on tx_valid.
  assign tx_ready   = (fifo_count != CW'(FIFO_DEPTH));
  assign push       = tx_valid && tx_ready;
  assign fifo_empty = (fifo_count == '0);
  assign bit_done   = (baud_cnt == '0);
  assign busy       = (state != IDLE) || !fifo_empty;
  // Divisors below 2 are clamped so every bit lasts at least two cycles.
  assign period_new = (clk_div < DIV_W'(2)) ? DIV_W'(2) : clk_div;

  // State register.
  always_ff @(posedge wb_clk_i) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic and FIFO pop request.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal
    // unassigned, which would otherwise infer a latch.
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        if (bit_done) state_nxt = DATA;
      end
      DATA: begin
        if (bit_done && (bit_cnt == 3'd7)) state_nxt = STOP;
      end
      STOP: begin
        if (bit_done) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO pointers and occupancy; a full FIFO refuses pushes even on a pop cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage write port.
  always_ff @(posedge wb_clk_i) begin
    // NOTE: the storage array is deliberately not reset; the pointers alone
    // define which entries are valid, and this lets it map onto plain RAM.
    if (push) mem[wr_ptr] <= tx_data;
  end

  // Serialiser datapath: baud counter, shift register and registered line.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tx_o     <= 1'b1;
      shift_q  <= '0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      period_q <= '0;
    end else if (pop) begin
      // Entering START (from IDLE or straight from STOP): load byte, latch period.
      shift_q  <= mem[rd_ptr];
      period_q <= period_new;
      baud_cnt <= period_new - DIV_W'(1);
      bit_cnt  <= '0;
      tx_o     <= 1'b0;
    end else begin
      case (state)
        START: begin
          if (bit_done) begin
            baud_cnt <= period_q - DIV_W'(1);
            tx_o     <= shift_q[0];
          end else begin
            baud_cnt <= baud_cnt - DIV_W'(1);
          end
        end
        DATA: begin
          if (bit_done) begin
            baud_cnt <= period_q - DIV_W'(1);
            if (bit_cnt == 3'd7) begin
              tx_o <= 1'b1;
            end else begin
              shift_q <= shift_q >> 1;
              tx_o    <= shift_q[1];
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - DIV_W'(1);
          end
        end
        STOP: begin
          tx_o <= 1'b1;
          if (!bit_done) baud_cnt <= baud_cnt - DIV_W'(1);
        end
        default: tx_o <= 1'b1;
      endcase
    end
  end

endmodule
